// File: rtl/lsb_serializer_pkg.sv
// lsb_serializer_pkg
// Items shared by the LSB-first serializer and its interface:
//   LSB_SER_WIDTH_DEF : default parallel word width
//   state_e           : serializer FSM states (IDLE, CLEAR, SHIFT)
package lsb_serializer_pkg;

  localparam int LSB_SER_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2
  } state_e;

endpackage

// File: rtl/lsb_serializer_if.sv
// lsb_serializer_if
// Bundles the parallel-in handshake and the serial-out bus of the serializer.
//   in_data/in_valid/in_ready : parallel word handshake (producer -> serializer)
//   ser_x/ser_clr/ser_valid/ser_last : serial stream to the downstream complementer
// Modports: master = producer/consumer side (testbench), slave = serializer.
interface lsb_serializer_if #(
  parameter int WIDTH = lsb_serializer_pkg::LSB_SER_WIDTH_DEF
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_x;
  logic             ser_clr;
  logic             ser_valid;
  logic             ser_last;

  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_x, ser_clr, ser_valid, ser_last
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, ser_x, ser_clr, ser_valid, ser_last
  );

endinterface

// File: rtl/lsb_serializer.sv
// lsb_serializer
// Accepts a WIDTH-bit word and emits it LSB first on ser_x, preceded by a
// one-cycle ser_clr pulse that resets the downstream serial complementer.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   io      : lsb_serializer_if.slave (in_data/in_valid/in_ready,
//             ser_x/ser_clr/ser_valid/ser_last)
// Optional feature: define LSB_SERIALIZER_BACK2BACK_EN to also accept a new
// word during the final SHIFT cycle (WIDTH+1 period instead of WIDTH+2).
module lsb_serializer
  import lsb_serializer_pkg::*;
#(
  parameter int WIDTH = LSB_SER_WIDTH_DEF
) (
  input logic          clk,
  input logic          reset_n,
  lsb_serializer_if.slave io
);

  localparam int CW = $clog2(WIDTH);
  // Counter stops at WIDTH-1 and never increments past it, so CW bits suffice.
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef LSB_SERIALIZER_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Low through reset and the first cycle after release; keeps in_ready low
  // while reset_n is asserted even though the FSM already sits in IDLE.
  logic             alive_q, alive_d;
  logic             ser_x_q, ser_x_d;
  logic             ser_clr_q, ser_clr_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_last_q, ser_last_d;

  logic last_bit;
  logic in_ready;
  logic accept;

  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_IDX);
  assign in_ready = alive_q &&
                    ((state_q == IDLE) || (B2B && last_bit));
  assign accept   = io.in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    alive_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = io.in_data;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        shift_d = shift_q >> 1;
        if (last_bit) begin
          // Hold the counter at WIDTH-1; it is re-cleared in CLEAR.
          if (accept) begin
            shift_d = io.in_data;
            state_d = CLEAR;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered: decode them from the next-state values so they
    // line up with the state they describe.
    ser_clr_d   = (state_d == CLEAR);
    ser_valid_d = (state_d == SHIFT);
    ser_x_d     = ser_valid_d && shift_d[0];
    ser_last_d  = ser_valid_d && (cnt_d == LAST_IDX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      alive_q     <= 1'b0;
      ser_x_q     <= 1'b0;
      ser_clr_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      alive_q     <= alive_d;
      ser_x_q     <= ser_x_d;
      ser_clr_q   <= ser_clr_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
    end
  end

  assign io.in_ready  = in_ready;
  assign io.ser_x     = ser_x_q;
  assign io.ser_clr   = ser_clr_q;
  assign io.ser_valid = ser_valid_q;
  assign io.ser_last  = ser_last_q;

endmodule

// File: tb/tb_lsb_serializer.sv
// tb_lsb_serializer
// Scoreboard bench: drivers push expected (bit, last) pairs when a word is
// accepted; monitors pop and compare whenever ser_valid is seen. A WIDTH=8
// and a WIDTH=2 instance share clock and reset. A behavioural serial
// two's-complementer on the WIDTH=8 stream checks the chained result.
module tb_lsb_serializer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

`ifdef LSB_SERIALIZER_BACK2BACK_EN
  localparam int PERIOD = 9;
`else
  localparam int PERIOD = 10;
`endif

  lsb_serializer_if #(.WIDTH(8)) if8 ();
  lsb_serializer_if #(.WIDTH(2)) if2 ();

  lsb_serializer #(.WIDTH(8)) dut8 (.clk(clk), .reset_n(reset_n), .io(if8.slave));
  lsb_serializer #(.WIDTH(2)) dut2 (.clk(clk), .reset_n(reset_n), .io(if2.slave));

  typedef struct packed {logic x; logic last;} exp_t;
  exp_t q8[$];
  exp_t q2[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int valid_cnt8 = 0;
  int clr_cnt8 = 0;
  int yidx = 0;
  logic [7:0] y_acc = '0;
  logic [7:0] y_word = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Downstream complementer: pass bits until the first 1, invert afterwards.
  logic cflag;
  logic y;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          cflag <= 1'b0;
    else if (if8.ser_clr)                  cflag <= 1'b0;
    else if (if8.ser_valid && if8.ser_x)   cflag <= 1'b1;
  end
  assign y = if8.ser_x ^ cflag;

  // Monitor for the WIDTH=8 instance
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (if8.ser_clr) begin
          clr_cnt8++;
          check("clr_quiet8", {30'd0, if8.ser_valid, if8.ser_x}, 32'd0);
          yidx = 0;
        end
        if (if8.ser_valid) begin
          valid_cnt8++;
          if (q8.size() == 0) begin
            check("spurious_bit8", 32'(q8.size()), 32'd1);
          end else begin
            e = q8.pop_front();
            check("ser_x8", {31'd0, if8.ser_x}, {31'd0, e.x});
            check("ser_last8", {31'd0, if8.ser_last}, {31'd0, e.last});
          end
          if (yidx < 8) y_acc[yidx[2:0]] = y;
          yidx++;
          if (if8.ser_last) y_word = y_acc;
        end
      end
    end
  end

  // Monitor for the WIDTH=2 instance
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && if2.ser_valid) begin
        if (q2.size() == 0) begin
          check("spurious_bit2", 32'(q2.size()), 32'd1);
        end else begin
          e = q2.pop_front();
          check("ser_x2", {31'd0, if2.ser_x}, {31'd0, e.x});
          check("ser_last2", {31'd0, if2.ser_last}, {31'd0, e.last});
        end
      end
    end
  end

  // Called just after a negedge. Returns at the negedge following acceptance.
  task automatic send8(input logic [7:0] w, input bit hold, output int acc_cyc);
    if8.in_data  = w;
    if8.in_valid = 1'b1;
    acc_cyc = -1;
    for (int i = 0; i < 60; i++) begin
      if (if8.in_ready) begin
        for (int k = 0; k < 8; k++) q8.push_back('{x: w[k], last: (k == 7)});
        @(negedge clk);
        acc_cyc = cyc;
        if (!hold) if8.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    timeout("accept8");
    if8.in_valid = 1'b0;
  endtask

  task automatic drain8();
    for (int i = 0; i < 60; i++) begin
      if (q8.size() == 0) begin
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    timeout("drain8");
    q8.delete();
  endtask

  initial begin
    int a0, a1, c0, v0;
    if8.in_data = '0; if8.in_valid = 1'b0;
    if2.in_data = '0; if2.in_valid = 1'b0;

    // Reset state
    #1;
    check("rst_outs8", {if8.ser_x, if8.ser_clr, if8.ser_valid, if8.ser_last}, 32'd0);
    check("rst_ready8", {31'd0, if8.in_ready}, 32'd0);
    check("rst_ready2", {31'd0, if2.in_ready}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    #1 check("ready_after_release8", {31'd0, if8.in_ready}, 32'd0);
    @(negedge clk);
    check("ready_first_cycle8", {31'd0, if8.in_ready}, 32'd1);
    check("ready_first_cycle2", {31'd0, if2.in_ready}, 32'd1);

    // Single word 8'h1C -> 0,0,1,1,1,0,0,0 preceded by one clear cycle
    c0 = clr_cnt8;
    send8(8'h1C, 1'b0, a0);
    check("ready_low_clear8", {31'd0, if8.in_ready}, 32'd0);
    check("clr_pulse8", {31'd0, if8.ser_clr}, 32'd1);
    drain8();
    check("clr_count_1c", 32'(clr_cnt8 - c0), 32'd1);

    // Stall: 8'hFF held valid during the previous word, accepted when ready
    send8(8'h1C, 1'b1, a0);
    send8(8'hFF, 1'b0, a1);
    check("stall_period", 32'(a1 - a0), 32'(PERIOD));
    drain8();

    // Back-to-back: 8'h01 then 8'h80 with in_valid held
    send8(8'h01, 1'b1, a0);
    send8(8'h80, 1'b0, a1);
    check("b2b_period", 32'(a1 - a0), 32'(PERIOD));
    drain8();

    // Chained complementer: 8'h0C -> y = 8'hF4
    send8(8'h0C, 1'b0, a0);
    drain8();
    check("complement_0c", {24'd0, y_word}, 32'h0000_00F4);

    // Reset pulsed mid-SHIFT
    send8(8'hA5, 1'b0, a0);
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_outs8", {if8.ser_x, if8.ser_clr, if8.ser_valid, if8.ser_last}, 32'd0);
    check("midrst_ready8", {31'd0, if8.in_ready}, 32'd0);
    q8.delete();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    #1 check("midrst_release_ready8", {31'd0, if8.in_ready}, 32'd0);
    @(posedge clk);
    #1 check("midrst_ready_next8", {31'd0, if8.in_ready}, 32'd1);
    v0 = valid_cnt8;
    repeat (12) @(negedge clk);
    check("midrst_no_valid8", 32'(valid_cnt8 - v0), 32'd0);

    // WIDTH=2 corner: 2'b10 -> 0 then 1 (last), then back to IDLE
    if2.in_data  = 2'b10;
    if2.in_valid = 1'b1;
    begin : w2_accept
      for (int i = 0; i < 20; i++) begin
        if (if2.in_ready) begin
          q2.push_back('{x: 1'b0, last: 1'b0});
          q2.push_back('{x: 1'b1, last: 1'b1});
          @(negedge clk);
          if2.in_valid = 1'b0;
          disable w2_accept;
        end
        @(negedge clk);
      end
      timeout("accept2");
    end
    repeat (4) @(negedge clk);
    check("w2_drained", 32'(q2.size()), 32'd0);
    check("w2_idle_ready", {31'd0, if2.in_ready}, 32'd1);
    repeat (6) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsb_serializer.md
LSB_SERIALIZER -- requirements
Module: lsb_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of bits per parallel word (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_data, input, WIDTH bits: parallel word to serialize.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a word this cycle.
REQ-007 SHALL have port ser_x, output, 1 bit: serial data bit, LSB first, driving the downstream complementer x input.
REQ-008 SHALL have port ser_clr, output, 1 bit: active-high one-cycle clear, driving the downstream complementer reset input.
REQ-009 SHALL have port ser_valid, output, 1 bit: ser_x carries a data bit this cycle.
REQ-010 SHALL have port ser_last, output, 1 bit: current ser_x is the MSB of the word.

Function
REQ-011 SHALL implement an FSM with states IDLE, CLEAR and SHIFT.
REQ-012 SHALL drive in_ready high combinationally in IDLE and low in CLEAR and SHIFT (see REQ-022 for the exception).
REQ-013 SHALL accept a word only on a rising edge with in_valid=1 and in_ready=1, latching in_data into a WIDTH-bit shift register and moving IDLE->CLEAR.
REQ-014 SHALL hold in_data ignored whenever no handshake occurs; in_valid without in_ready has no effect.
REQ-015 SHALL, in CLEAR, drive ser_clr=1, ser_x=0 and ser_valid=0 for exactly one cycle, then move to SHIFT.
REQ-016 SHALL, in SHIFT, drive ser_valid=1 and ser_x=shift_reg[0], shifting right by one each cycle, for exactly WIDTH cycles with bit k presented on the k-th SHIFT cycle (k=0..WIDTH-1).
REQ-017 SHALL drive ser_last=1 only on the SHIFT cycle with bit WIDTH-1; otherwise 0.
REQ-018 SHALL, after the last SHIFT cycle, return to IDLE; the minimum accept-to-accept period is WIDTH+2 cycles.
REQ-019 SHALL use a bit counter of width $clog2(WIDTH), cleared on entering SHIFT; it SHALL NOT wrap or overflow for any legal WIDTH.
REQ-020 SHALL drive ser_clr=0, ser_valid=0, ser_last=0 and ser_x=0 in IDLE.

Reset
REQ-021 SHALL, on reset_n=0 at any time including mid-word, immediately force IDLE, clear the shift register and counter, drop the in-flight word, and hold ser_x=0, ser_clr=0, ser_valid=0, ser_last=0, in_ready=0 until reset_n is deasserted; in_ready rises in the first cycle after deassertion.

Configuration
REQ-022 SHALL, with macro LSB_SERIALIZER_BACK2BACK_EN defined, assert in_ready also during the ser_last SHIFT cycle; a handshake there moves SHIFT->CLEAR directly, giving a period of WIDTH+1 cycles.
REQ-023 SHALL, without LSB_SERIALIZER_BACK2BACK_EN, behave exactly as REQ-012 and REQ-018.

Structure
REQ-024 SHALL take the state enum (IDLE, CLEAR, SHIFT) and the default WIDTH constant from a shared package lsb_serializer_pkg.
REQ-025 SHALL be a single module; no sub-module is warranted.

Verification
REQ-026 Reset: reset_n=0 pulsed mid-SHIFT -> all outputs 0 immediately; in_ready=1 one cycle after release; no further ser_valid.
REQ-027 Single word: WIDTH=8, in_data=8'h1C accepted -> ser_clr=1 for 1 cycle, then ser_x=0,0,1,1,1,0,0,0 with ser_valid=1 for 8 cycles, ser_last on the 8th.
REQ-028 Stall: in_valid=1 held during SHIFT with in_data=8'hFF -> word ignored until in_ready=1; then serialized as 8 ones.
REQ-029 Back-to-back: 8'h01 then 8'h80 with in_valid held -> accept period 10 cycles without the macro, 9 cycles with it; ser_x streams 1,0,0,0,0,0,0,0 and 0,0,0,0,0,0,0,1.
REQ-030 Chained with the complementer: 8'h0C serialized -> complementer y stream equals 8'hF4 LSB-first (0,0,1,0,1,1,1,1).
REQ-031 Width corner: WIDTH=2, in_data=2'b10 -> ser_x=0,1, with ser_last on the second bit and no counter wrap.
